pipeline_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage segmented RISC-V pipeline. It drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB segment registers. It also drives the PC enable and redirect select, and the EX-stage forwarding muxes. It resolves load-use stalls, taken-branch flushes and multi-cycle data-memory waits, and keeps stall/flush performance counters.

---
 rtl/pipeline_ctrl_pkg.sv | 18 +
 rtl/forward_unit.sv | 31 +++
 rtl/pipeline_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and widths for the pipeline hazard/sequencing controller.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    REDIRECT = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/forward_unit.sv
// EX-stage operand forwarding select; EX/MEM beats MEM/WB and x0 is never forwarded.
module forward_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b
);

  function automatic fwd_sel_t fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                       input logic [REG_ADDR_W-1:0] m_rd,
                                       input logic                  m_we,
                                       input logic [REG_ADDR_W-1:0] w_rd,
                                       input logic                  w_we);
    if (m_we && (m_rd != '0) && (m_rd == rs)) begin
      return FWD_MEM;
    end else if (w_we && (w_rd != '0) && (w_rd == rs)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

  assign fwd_a = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
  assign fwd_b = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: load-use stalls, branch flushes, dmem waits and perf counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REDIRECT_EXTRA = 1,
  parameter int unsigned MEM_TIMEOUT    = 64,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_en,
  output logic                  pc_redirect,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_en,
  output logic                  id_ex_flush,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

  state_t             state_q, state_d;
  logic [2:0]         redir_cnt_q, redir_cnt_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   flush_q, flush_d;
  logic               mem_wait, load_use, branch_fire;
  logic [1:0]         fwd_a_raw, fwd_b_raw;

  forward_unit u_forward_unit (
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_a         (fwd_a_raw),
    .fwd_b         (fwd_b_raw)
  );

  assign mem_wait = dmem_req && !dmem_ready;
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));

  always_comb begin
    pc_en       = 1'b1;
    pc_redirect = 1'b0;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b1;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    branch_fire = 1'b0;
    state_d     = RUN;
    redir_cnt_d = redir_cnt_q;
    wait_cnt_d  = '0;

    if (mem_wait) begin
      pc_en      = 1'b0;
      if_id_en   = 1'b0;
      id_ex_en   = 1'b0;
      ex_mem_en  = 1'b0;
      mem_wb_en  = 1'b0;
      state_d    = MEM_WAIT;
      wait_cnt_d = (wait_cnt_q == WaitMax) ? wait_cnt_q : wait_cnt_q + WaitW'(1);
    end else if (ex_branch_taken) begin
      pc_redirect = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      branch_fire = 1'b1;
      if (REDIRECT_EXTRA > 0) begin
        state_d     = REDIRECT;
        redir_cnt_d = 3'(REDIRECT_EXTRA);
      end
    end else if (state_q == REDIRECT) begin
      // Fetch is still returning wrong-path words for the imem latency.
      if_id_flush = 1'b1;
      if (redir_cnt_q > 3'd1) begin
        state_d     = REDIRECT;
        redir_cnt_d = redir_cnt_q - 3'd1;
      end
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end

    timeout_d = timeout_q | (wait_cnt_d == WaitMax);
    stall_d   = (!pc_en && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
    flush_d   = (branch_fire && (flush_q != '1)) ? flush_q + CNT_W'(1) : flush_q;

    // Reset must reach the pipeline immediately, not at the next edge.
    if (!rst_n) begin
      pc_en       = 1'b0;
      pc_redirect = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_en    = 1'b0;
      id_ex_flush = 1'b1;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      redir_cnt_q <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_q     <= '0;
      flush_q     <= '0;
    end else begin
      state_q     <= state_d;
      redir_cnt_q <= redir_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_q     <= stall_d;
      flush_q     <= flush_d;
    end
  end

  assign fwd_a       = rst_n ? fwd_a_raw : FWD_RF;
  assign fwd_b       = rst_n ? fwd_b_raw : FWD_RF;
  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and randomized checks of pipeline_ctrl against a cycle-level behavioural model.
module tb_pipeline_ctrl;

  localparam int unsigned EXTRA   = 1;
  localparam int unsigned MT      = 4;
  localparam int unsigned CW      = 8;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
  logic       mem_reg_write, wb_reg_write, dmem_req, dmem_ready;
  logic       pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic       ex_mem_en, mem_wb_en, mem_timeout;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_redir_left, m_wait_cycles, m_stall, m_flush;
  bit m_timeout;

  pipeline_ctrl #(
    .REDIRECT_EXTRA (EXTRA),
    .MEM_TIMEOUT    (MT),
    .CNT_W          (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_rs1          (ex_rs1),
    .ex_rs2          (ex_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_rd          (mem_rd),
    .mem_reg_write   (mem_reg_write),
    .wb_rd           (wb_rd),
    .wb_reg_write    (wb_reg_write),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en),
    .pc_redirect     (pc_redirect),
    .if_id_en        (if_id_en),
    .if_id_flush     (if_id_flush),
    .id_ex_en        (id_ex_en),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .mem_timeout     (mem_timeout),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_fwd(input int rs, input int mrd, input bit mwe,
                                 input int wrd, input bit wwe);
    if (mwe && mrd != 0 && mrd == rs) return 1;
    if (wwe && wrd != 0 && wrd == rs) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_redir_left  = 0;
    m_wait_cycles = 0;
    m_stall       = 0;
    m_flush       = 0;
    m_timeout     = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc_en"}, 32'(pc_en), 0);
    chk({tag, "_redirect"}, 32'(pc_redirect), 0);
    chk({tag, "_if_id_en"}, 32'(if_id_en), 0);
    chk({tag, "_if_id_flush"}, 32'(if_id_flush), 1);
    chk({tag, "_id_ex_en"}, 32'(id_ex_en), 0);
    chk({tag, "_id_ex_flush"}, 32'(id_ex_flush), 1);
    chk({tag, "_ex_mem_en"}, 32'(ex_mem_en), 0);
    chk({tag, "_mem_wb_en"}, 32'(mem_wb_en), 0);
    chk({tag, "_fwd_a"}, 32'(fwd_a), 0);
    chk({tag, "_fwd_b"}, 32'(fwd_b), 0);
    chk({tag, "_timeout"}, 32'(mem_timeout), 0);
    chk({tag, "_stall_cnt"}, 32'(stall_cnt), 0);
    chk({tag, "_flush_cnt"}, 32'(flush_cnt), 0);
  endtask

  // Called at edge+1 with inputs settled; checks, clocks, advances the model.
  task automatic cycle();
    bit wt, br, redir, lu;
    bit e_pc, e_ifen, e_rest, e_redir, e_iff, e_idf;
    #3;
    wt    = dmem_req && !dmem_ready;
    br    = !wt && ex_branch_taken;
    redir = !wt && !br && m_redir_left > 0;
    lu    = !wt && !br && !redir && ex_mem_read && ex_rd != 0 &&
            ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
    e_rest  = !wt;
    e_pc    = !wt && !lu;
    e_ifen  = e_pc;
    e_redir = br;
    e_iff   = br || redir;
    e_idf   = br || lu;
    chk("pc_en", 32'(pc_en), 32'(e_pc));
    chk("pc_redirect", 32'(pc_redirect), 32'(e_redir));
    chk("if_id_en", 32'(if_id_en), 32'(e_ifen));
    chk("if_id_flush", 32'(if_id_flush), 32'(e_iff));
    chk("id_ex_en", 32'(id_ex_en), 32'(e_rest));
    chk("id_ex_flush", 32'(id_ex_flush), 32'(e_idf));
    chk("ex_mem_en", 32'(ex_mem_en), 32'(e_rest));
    chk("mem_wb_en", 32'(mem_wb_en), 32'(e_rest));
    chk("fwd_a", 32'(fwd_a), 32'(exp_fwd(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write)));
    chk("fwd_b", 32'(fwd_b), 32'(exp_fwd(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write)));
    chk("mem_timeout", 32'(mem_timeout), 32'(m_timeout));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    @(posedge clk);
    if (wt) begin
      m_wait_cycles++;
      if (m_wait_cycles >= MT) m_timeout = 1;
      m_redir_left = 0;
    end else begin
      m_wait_cycles = 0;
      if (br) begin
        if (m_flush < CNT_MAX) m_flush++;
        m_redir_left = EXTRA;
      end else if (redir) begin
        m_redir_left--;
      end
    end
    if (!e_pc && m_stall < CNT_MAX) m_stall++;
    #1;
  endtask

  task automatic clear_inputs();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken} = '0;
    {mem_reg_write, wb_reg_write, dmem_req, dmem_ready} = '0;
  endtask

  task automatic rand_inputs(input int ready_pct);
    id_rs1          = 5'($urandom_range(0, 3));
    id_rs2          = 5'($urandom_range(0, 3));
    ex_rs1          = 5'($urandom_range(0, 3));
    ex_rs2          = 5'($urandom_range(0, 3));
    ex_rd           = 5'($urandom_range(0, 3));
    mem_rd          = 5'($urandom_range(0, 3));
    wb_rd           = 5'($urandom_range(0, 3));
    id_use_rs1      = 1'($urandom_range(0, 1));
    id_use_rs2      = 1'($urandom_range(0, 1));
    ex_mem_read     = 1'($urandom_range(0, 1));
    ex_branch_taken = ($urandom_range(0, 2) == 0);
    mem_reg_write   = 1'($urandom_range(0, 1));
    wb_reg_write    = 1'($urandom_range(0, 1));
    dmem_req        = 1'($urandom_range(0, 1));
    dmem_ready      = ($urandom_range(0, 99) < ready_pct);
  endtask

  initial begin
    clear_inputs();
    model_reset();
    #3;
    chk_reset("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Load-use on rs1
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    cycle();
    chk("lu_stall_cnt", 32'(stall_cnt), 1);
    ex_mem_read = 1'b0;
    cycle();

    // Taken branch, one extra flush cycle
    ex_branch_taken = 1'b1;
    cycle();
    ex_branch_taken = 1'b0;
    cycle();
    cycle();
    chk("br_flush_cnt", 32'(flush_cnt), 1);

    // Memory wait with a branch parked in EX
    dmem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
    repeat (3) cycle();
    dmem_ready = 1'b1;
    cycle();
    dmem_req = 1'b0; ex_branch_taken = 1'b0;
    cycle();
    chk("mw_stall_cnt", 32'(stall_cnt), 4);
    chk("mw_flush_cnt", 32'(flush_cnt), 2);

    // Timeout after MT wait cycles, sticky past completion
    dmem_req = 1'b1; dmem_ready = 1'b0;
    repeat (6) cycle();
    dmem_ready = 1'b1;
    cycle();
    dmem_req = 1'b0;
    cycle();
    chk("to_sticky", 32'(mem_timeout), 1);

    // Forwarding priority and x0
    mem_rd = 5'd7; wb_rd = 5'd7; mem_reg_write = 1'b1; wb_reg_write = 1'b1; ex_rs1 = 5'd7;
    #1;
    chk("fwd_mem_prio", 32'(fwd_a), 1);
    ex_rs2 = 5'd0; wb_rd = 5'd0;
    #1;
    chk("fwd_x0", 32'(fwd_b), 0);
    #1;
    cycle();

    // Async reset in the middle of a memory wait
    mem_rd = 5'd3; ex_rs1 = 5'd3; ex_rs2 = 5'd3; mem_reg_write = 1'b1;
    dmem_req = 1'b1; dmem_ready = 1'b0;
    cycle();
    cycle();
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset("mid_wait");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_inputs();

    // Randomized traffic: mixed, then long memory waits
    for (int i = 0; i < 2500; i++) begin
      rand_inputs(50);
      cycle();
    end
    for (int i = 0; i < 1000; i++) begin
      rand_inputs(12);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
